// File: rtl/program_loader.sv
// Framed byte-stream boot loader: parses A5/LEN/words/CHK frames, issues one debug
// instruction-memory write per 4-byte word and releases the core only on a good checksum.
module program_loader #(
    parameter int                XLEN               = 64,
    parameter int                INSTRUCTION_LENGTH = 32,
    parameter logic [XLEN-1:0]   BASE_ADDR          = '0,
    parameter int unsigned       ADDR_STEP          = 4,
    parameter int unsigned       TIMEOUT_CYCLES     = 1000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          dbg_wr_en,
    output logic [XLEN-1:0]               dbg_addr,
    output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
    output logic                          cpu_rst,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    error,
    output logic [15:0]                   words_written,
    output logic [2:0]                    dbg_state
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                        state_q, state_d;
    logic [15:0]                   len_q, len_d;
    logic [7:0]                    chk_q, chk_d;
    logic [INSTRUCTION_LENGTH-9:0] word_q, word_d;
    logic [1:0]                    byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]              tmo_q, tmo_d;
    logic                          wr_en_q, wr_en_d;
    logic [XLEN-1:0]               addr_q, addr_d;
    logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
    logic                          cpu_rst_q, cpu_rst_d;
    logic                          done_q, done_d;
    logic [1:0]                    error_q, error_d;
    logic [15:0]                   ww_q, ww_d;
    logic                          accept;
    logic                          counting;

    // Ready is a pure decode of the current state so no byte can land in WRITE/DONE.
    assign in_ready = ~rst & (state_q != S_WRITE) & (state_q != S_DONE);
    assign accept   = in_valid & in_ready;
    assign counting = (state_q == S_LEN_LO) | (state_q == S_LEN_HI) |
                      (state_q == S_DATA)   | (state_q == S_CHECK);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        chk_d      = chk_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        instr_d    = instr_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = 1'b0;
        error_d    = error_q;
        ww_d       = ww_q;

        if (accept) begin
            tmo_d = '0;
        end else if (counting) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept && in_data == 8'hA5) begin
                    error_d   = 2'b00;
                    ww_d      = '0;
                    chk_d     = '0;
                    cpu_rst_d = 1'b1;
                    state_d   = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    chk_d      = chk_q ^ in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    chk_d       = chk_q ^ in_data;
                    byte_cnt_d  = '0;
                    state_d     = ({in_data, len_q[7:0]} == 16'd0) ? S_CHECK : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Bytes enter at the top so byte 0 ends up in the low lane.
                    word_d     = {in_data, word_q[INSTRUCTION_LENGTH-9:8]};
                    chk_d      = chk_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d = 1'b1;
                        instr_d = {in_data, word_q};
                        addr_d  = BASE_ADDR + XLEN'(ww_q) * XLEN'(ADDR_STEP);
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ww_d    = ww_q + 16'd1;
                state_d = (ww_q + 16'd1 == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        error_d = 2'b01;
                        state_d = S_ERROR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (!accept && counting && (32'(tmo_q) + 32'd1 == TIMEOUT_CYCLES)) begin
            error_d = 2'b10;
            tmo_d   = '0;
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            chk_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 2'b00;
            ww_q       <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            chk_q      <= chk_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ww_q       <= ww_d;
        end
    end

    assign dbg_wr_en     = wr_en_q;
    assign dbg_addr      = addr_q;
    assign dbg_instr     = instr_q;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table frames, hand-written corner sequences and random
// frames checked against a frame-level model feeding an expected-write queue.
module tb_program_loader;
    localparam int XLEN = 64;
    localparam int TMO  = 16;

    logic            clk, rst, in_valid, in_ready, dbg_wr_en, cpu_rst, busy, done;
    logic [7:0]      in_data;
    logic [XLEN-1:0] dbg_addr;
    logic [31:0]     dbg_instr;
    logic [1:0]      error;
    logic [15:0]     words_written;
    logic [2:0]      dbg_state;

    program_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .error(error), .words_written(words_written),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [95:0] exp_q[$];
    logic [7:0]  tx_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue; ready may drop
    // only in the write-strobe and done-pulse cycles.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_gap", 64'(!in_ready), 64'(dbg_wr_en | done));
            if (dbg_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(dbg_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [95:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", dbg_addr, e[95:32]);
                    check("write_data", 64'(dbg_instr), 64'(e[31:0]));
                end
            end
            if (done) done_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the byte was transferred.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("ready_wait", 64'(n), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int max_gap);
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic end_frame(input string tag, input logic [1:0] e_err, input int e_done,
                             input logic e_crst, input logic [15:0] e_ww, input int done_before);
        repeat (4) @(negedge clk);
        check({tag, "_error"}, 64'(error), 64'(e_err));
        check({tag, "_done"}, 64'(done_cnt - done_before), 64'(e_done));
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(e_crst));
        check({tag, "_words"}, 64'(words_written), 64'(e_ww));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Frame-level reference: build a frame from words and queue the writes it must cause.
    task automatic model_frame(input int n, input bit corrupt, input int junk);
        logic [7:0]  chk;
        logic [31:0] w;
        for (int j = 0; j < junk; j++) begin
            logic [7:0] jb;
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h00;
            tx_q.push_back(jb);
        end
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'(n));
        tx_q.push_back(8'h00);
        chk = 8'(n);
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(0, 5) == 0) ? 32'hA5A5_A5A5 : $urandom;
            for (int k = 0; k < 4; k++) begin
                tx_q.push_back(w[8*k +: 8]);
                chk = chk ^ w[8*k +: 8];
            end
            exp_q.push_back({64'(i * 4), w});
        end
        tx_q.push_back(corrupt ? (chk ^ 8'h5A) : chk);
    endtask

    typedef struct {
        int           nb;
        logic [127:0] b;
        int           nw;
        logic [63:0]  w;
        logic [1:0]   err;
        int           dn;
        logic         crst;
        logic [15:0]  ww;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int d0;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;

        vecs[0] = '{12, {96'hA5_02_00_13_00_00_00_93_00_10_00_92, 32'h0}, 2,
                    64'h00000013_00100093, 2'b00, 1, 1'b0, 16'd2};
        vecs[1] = '{12, {96'hA5_02_00_13_00_00_00_93_00_10_00_70, 32'h0}, 2,
                    64'h00000013_00100093, 2'b01, 0, 1'b1, 16'd2};
        vecs[2] = '{6, {48'h00_FF_A5_00_00_00, 80'h0}, 0, 64'h0, 2'b00, 1, 1'b0, 16'd0};
        vecs[3] = '{8, {64'hA5_01_00_A5_A5_A5_A5_01, 64'h0}, 1,
                    64'hA5A5A5A5_00000000, 2'b00, 1, 1'b0, 16'd1};

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(dbg_wr_en), 64'd0);
        check("rst_addr", dbg_addr, 64'd0);
        check("rst_instr", 64'(dbg_instr), 64'd0);
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            for (int i = 0; i < vecs[v].nw; i++)
                exp_q.push_back({64'(i * 4), (i == 0) ? vecs[v].w[63:32] : vecs[v].w[31:0]});
            for (int i = 0; i < vecs[v].nb; i++)
                tx_q.push_back(vecs[v].b[127 - 8*i -: 8]);
            send_tx(0);
            end_frame($sformatf("vec%0d", v), vecs[v].err, vecs[v].dn, vecs[v].crst, vecs[v].ww, d0);
        end

        // Reload after a good load: header re-asserts core reset.
        d0 = done_cnt;
        send_byte(8'hA5);
        check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
        check("reload_busy", 64'(busy), 64'd1);
        exp_q.push_back({64'd0, 32'hDEADBEEF});
        foreach (tx_q[i]) tx_q.delete(i);
        tx_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        send_tx(0);
        end_frame("reload", 2'b00, 1, 1'b0, 16'd1, d0);

        // Timeout after A5 01 with the bus idle.
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", 64'(error), 64'd0);
        @(negedge clk);
        check("tmo_error", 64'(error), 64'b10);
        @(negedge clk);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_cpu_rst", 64'(cpu_rst), 64'd1);
        check("tmo_no_writes", 64'(words_written), 64'd0);
        check("tmo_done", 64'(done_cnt - d0), 64'd0);

        // Reset in the middle of a data word.
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        send_tx(0);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("mrst_addr", dbg_addr, 64'd0);
        check("mrst_instr", 64'(dbg_instr), 64'd0);
        check("mrst_error", 64'(error), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ready_back", 64'(in_ready), 64'd1);

        for (int f = 0; f < 25; f++) begin
            int  n;
            bit  bad;
            n   = $urandom_range(0, 4);
            bad = ($urandom_range(0, 3) == 0);
            d0  = done_cnt;
            model_frame(n, bad, $urandom_range(0, 2));
            send_tx(3);
            end_frame($sformatf("rnd%0d", f), bad ? 2'b01 : 2'b00, bad ? 0 : 1,
                      bad, 16'(n), d0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_time_limit actual=expired required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
